// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Package     : usr_pkg
// Description : Shared mode encoding and next-value helper for the
//               universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  // Operation select carried on io_mode
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHL   = 3'd1,
    MODE_SHR   = 3'd2,
    MODE_SAR   = 3'd3,
    MODE_ROL   = 3'd4,
    MODE_ROR   = 3'd5,
    MODE_LOAD  = 3'd6,
    MODE_CLEAR = 3'd7
  } mode_t;

  // Next register value for a register of 'width' bits held right-aligned in
  // a 64-bit container; inputs must already be zero above 'width'.
  function automatic logic [63:0] usr_next_q(
    input mode_t       mode,
    input logic [63:0] q,
    input logic        sin,
    input logic [63:0] pin,
    input int unsigned width
  );
    logic [63:0] mask;
    logic [63:0] top;
    logic [63:0] r;
    logic        msb;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    top  = 64'd1 << (width - 1);
    msb  = |(q & top);
    case (mode)
      MODE_SHL:   r = (q << 1) | {63'd0, sin};
      MODE_SHR:   r = (q >> 1) | (sin ? top : 64'd0);
      MODE_SAR:   r = (q >> 1) | (msb ? top : 64'd0);
      MODE_ROL:   r = (q << 1) | {63'd0, msb};
      MODE_ROR:   r = (q >> 1) | (q[0] ? top : 64'd0);
      MODE_LOAD:  r = pin;
      MODE_CLEAR: r = 64'd0;
      default:    r = q;
    endcase
    return r & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/universal_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Interface   : universal_shift_reg_if
// Description : Control/data bundle of the universal shift register.
//               Carries io_parity when UNIVERSAL_SHIFT_REG_PARITY_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             io_enable;
  logic [2:0]       io_mode;
  logic             io_serialIn;
  logic [WIDTH-1:0] io_parallelIn;
  logic [WIDTH-1:0] io_q;
  logic             io_serialOutMsb;
  logic             io_serialOutLsb;
  logic [CNT_W-1:0] io_remaining;
  logic             io_empty;
`ifdef UNIVERSAL_SHIFT_REG_PARITY_EN
  logic             io_parity;
`endif

  // Stimulus side
  modport master (
    output io_enable, io_mode, io_serialIn, io_parallelIn,
    input  io_q, io_serialOutMsb, io_serialOutLsb, io_remaining, io_empty
`ifdef UNIVERSAL_SHIFT_REG_PARITY_EN
    , input io_parity
`endif
  );

  // Register side
  modport slave (
    input  io_enable, io_mode, io_serialIn, io_parallelIn,
    output io_q, io_serialOutMsb, io_serialOutLsb, io_remaining, io_empty
`ifdef UNIVERSAL_SHIFT_REG_PARITY_EN
    , output io_parity
`endif
  );

endinterface
`default_nettype wire

// File: rtl/usr_remaining_counter.sv
`default_nettype none
// ============================================================================
// Module      : usr_remaining_counter
// Description : Count of loaded bits not yet shifted out. Loads to WIDTH,
//               clears to 0, decrements saturating at 0.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_remaining_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             load_i,
  input  wire logic             clear_i,
  input  wire logic             dec_i,
  output logic      [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear and load are absolute, decrement stops at zero
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = CNT_W'(WIDTH);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_reg
// Description : WIDTH-bit register with load, clear, logical/arithmetic
//               shift and rotate, serial I/O at both ends and a count of
//               loaded bits still unshifted.
//               Optional registered parity: UNIVERSAL_SHIFT_REG_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input wire logic              clock,
  input wire logic              reset,
  universal_shift_reg_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] remaining;
  mode_t            mode_eff;

  // Disabled cycles behave exactly like HOLD
  assign mode_eff = bus.io_enable ? mode_t'(bus.io_mode) : MODE_HOLD;

  // Next data value from the shared helper
  always_comb begin
    q_d = WIDTH'(usr_next_q(mode_eff, 64'(q_q), bus.io_serialIn,
                            64'(bus.io_parallelIn), WIDTH));
  end

  // Data register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  usr_remaining_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_remaining (
    .clock   (clock),
    .reset   (reset),
    .load_i  (mode_eff == MODE_LOAD),
    .clear_i (mode_eff == MODE_CLEAR),
    .dec_i   ((mode_eff == MODE_SHL) || (mode_eff == MODE_SHR) ||
              (mode_eff == MODE_SAR)),
    .count_o (remaining)
  );

  assign bus.io_q            = q_q;
  assign bus.io_serialOutMsb = q_q[WIDTH-1];
  assign bus.io_serialOutLsb = q_q[0];
  assign bus.io_remaining    = remaining;
  assign bus.io_empty        = (remaining == '0);

`ifdef UNIVERSAL_SHIFT_REG_PARITY_EN
  logic parity_q;

  // Parity of the incoming value, so it lines up with io_q without a
  // combinational XOR tree on the output
  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign bus.io_parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_reg
// Description : Directed-vector bench for universal_shift_reg (WIDTH = 8)
//               with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;

  localparam int W = 8;
  localparam int unsigned M = 1 << W;        // modulus of the register
  localparam int unsigned H = 1 << (W - 1);  // weight of the MSB

  localparam int HOLD = 0, SHL = 1, SHR = 2, SAR = 3;
  localparam int ROL = 4, ROR = 5, LOAD = 6, CLR = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  universal_shift_reg_if #(.WIDTH(W)) bus ();

  universal_shift_reg #(.WIDTH(W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_err    = 0;
  int unsigned m_q      = 0;
  int unsigned m_rem    = 0;
  bit          armed    = 1'b0;

  // Register value after one operation, as plain arithmetic on an integer
  function automatic int unsigned model_next(int unsigned q, int mode,
                                             bit sin, int unsigned pin);
    case (mode)
      SHL:     return (q * 2 + sin) % M;
      SHR:     return q / 2 + (sin ? H : 0);
      SAR:     return q / 2 + ((q >= H) ? H : 0);
      ROL:     return (q * 2) % M + q / H;
      ROR:     return q / 2 + (q % 2) * H;
      LOAD:    return pin % M;
      CLR:     return 0;
      default: return q;
    endcase
  endfunction

  function automatic int unsigned model_rem(int unsigned r, int mode);
    case (mode)
      SHL, SHR, SAR: return (r > 0) ? r - 1 : 0;
      LOAD:          return W;
      CLR:           return 0;
      default:       return r;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (armed) begin
      check("model_q",     64'(bus.io_q),            64'(m_q));
      check("model_msb",   64'(bus.io_serialOutMsb), 64'(m_q / H));
      check("model_lsb",   64'(bus.io_serialOutLsb), 64'(m_q % 2));
      check("model_rem",   64'(bus.io_remaining),    64'(m_rem));
      check("model_empty", 64'(bus.io_empty),        64'(m_rem == 0));
`ifdef UNIVERSAL_SHIFT_REG_PARITY_EN
      check("model_parity", 64'(bus.io_parity), 64'($countones(m_q) % 2));
`endif
    end
  end

  // Apply one cycle of stimulus and advance the model on the same edge
  task automatic step(input bit r, input bit en, input int mode,
                      input bit sin, input int unsigned pin);
    @(negedge clk);
    rst               = r;
    bus.io_enable     = en;
    bus.io_mode       = 3'(mode);
    bus.io_serialIn   = sin;
    bus.io_parallelIn = W'(pin);
    @(posedge clk);
    if (r) begin
      m_q   = 0;
      m_rem = 0;
    end else if (en) begin
      m_q   = model_next(m_q, mode, sin, pin);
      m_rem = model_rem(m_rem, mode);
    end
    armed = 1'b1;
    #1;
  endtask

  task automatic op(input int mode, input bit sin, input int unsigned pin);
    step(1'b0, 1'b1, mode, sin, pin);
  endtask

  initial begin
    bus.io_enable     = 1'b0;
    bus.io_mode       = 3'd0;
    bus.io_serialIn   = 1'b0;
    bus.io_parallelIn = '0;

    // Reset state
    step(1'b1, 1'b0, HOLD, 1'b0, 0);
    step(1'b1, 1'b0, HOLD, 1'b0, 0);
    check("rst_q",     64'(bus.io_q),         64'h0);
    check("rst_rem",   64'(bus.io_remaining), 64'd0);
    check("rst_empty", 64'(bus.io_empty),     64'd1);

    // LOAD then SHL
    op(LOAD, 1'b0, 'h81);
    check("ld81_q",   64'(bus.io_q),            64'h81);
    check("ld81_rem", 64'(bus.io_remaining),    64'd8);
    check("ld81_msb", 64'(bus.io_serialOutMsb), 64'd1);
    op(SHL, 1'b1, 0);
    check("shl_q",   64'(bus.io_q),         64'h03);
    check("shl_rem", 64'(bus.io_remaining), 64'd7);

    // Arithmetic shift right, then logical shift right
    op(LOAD, 1'b1, 'h80);
    op(SAR, 1'b1, 0);
    check("sar1_q", 64'(bus.io_q), 64'hC0);
    op(SAR, 1'b0, 0);
    check("sar2_q", 64'(bus.io_q), 64'hE0);
    op(SAR, 1'b0, 0);
    check("sar3_q",   64'(bus.io_q),         64'hF0);
    check("sar3_rem", 64'(bus.io_remaining), 64'd5);
    op(SHR, 1'b0, 0);
    check("shr_q", 64'(bus.io_q), 64'h78);
    op(SHR, 1'b1, 0);
    check("shr1_q", 64'(bus.io_q), 64'hBC);

    // Rotations keep the count
    op(LOAD, 1'b0, 'h01);
    op(ROR, 1'b0, 0);
    check("ror_q", 64'(bus.io_q), 64'h80);
    op(ROL, 1'b0, 0);
    check("rol1_q", 64'(bus.io_q), 64'h01);
    op(ROL, 1'b1, 0);
    check("rol2_q",   64'(bus.io_q),         64'h02);
    check("rol_rem",  64'(bus.io_remaining), 64'd8);

    // Drain to empty and saturate
    op(LOAD, 1'b0, 'hA5);
    for (int i = 0; i < 8; i++) op(SHL, 1'b0, 0);
    check("drain_q",     64'(bus.io_q),         64'h00);
    check("drain_rem",   64'(bus.io_remaining), 64'd0);
    check("drain_empty", 64'(bus.io_empty),     64'd1);
    op(SHL, 1'b1, 0);
    check("sat_rem", 64'(bus.io_remaining), 64'd0);
    check("sat_q",   64'(bus.io_q),         64'h01);

    // Disabled cycles hold even with LOAD presented
    op(LOAD, 1'b0, 'h5A);
    op(SHR, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, LOAD, 1'b1, 'hFF);
    check("dis_q",   64'(bus.io_q),         64'hAD);
    check("dis_rem", 64'(bus.io_remaining), 64'd7);
    op(HOLD, 1'b1, 'hFF);
    check("hold_q", 64'(bus.io_q), 64'hAD);

    // CLEAR
    op(CLR, 1'b1, 'hFF);
    check("clr_q",     64'(bus.io_q),     64'h00);
    check("clr_empty", 64'(bus.io_empty), 64'd1);

    // Reset wins over a concurrent LOAD
    op(LOAD, 1'b0, 'h99);
    step(1'b1, 1'b1, LOAD, 1'b0, 'h3C);
    check("rstld_q",     64'(bus.io_q),     64'h00);
    check("rstld_empty", 64'(bus.io_empty), 64'd1);

`ifdef UNIVERSAL_SHIFT_REG_PARITY_EN
    op(LOAD, 1'b0, 'h07);
    check("par_ld", 64'(bus.io_parity), 64'd1);
    op(SHL, 1'b1, 0);
    check("par_shl_q", 64'(bus.io_q),      64'h0F);
    check("par_shl",   64'(bus.io_parity), 64'd0);
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
